// File: rtl/alu_arbiter_seq.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered onto the ALU, held for SETTLE cycles, then the result is returned on a tagged channel.
module alu_arbiter_seq #(
  parameter int W      = 4,
  parameter int SEL_W  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  input  logic [SEL_W-1:0] req1_sel,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [W-1:0]     alu_y,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_y,
  output logic [3:0]       rsp_flags,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Counter only needs to hold SETTLE-1; keep at least one bit for SETTLE=1.
  localparam int              SC_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0] SC_INIT = SC_W'(SETTLE - 1);

  logic [1:0]      state;
  logic            last;
  logic [SC_W-1:0] sc;

  // last==1 means requester 1 won most recently, so requester 0 has priority.
  assign req0_ready = (state == IDLE) && req0_valid && (!req1_valid || last);
  assign req1_ready = (state == IDLE) && req1_valid && (!req0_valid || !last);
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      sc        <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_id    <= 1'b0;
      rsp_y     <= '0;
      rsp_flags <= '0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            alu_a   <= req0_a;
            alu_b   <= req0_b;
            alu_sel <= req0_sel;
            rsp_id  <= 1'b0;
            last    <= 1'b0;
            sc      <= SC_INIT;
            state   <= EXEC;
          end else if (req1_ready) begin
            alu_a   <= req1_a;
            alu_b   <= req1_b;
            alu_sel <= req1_sel;
            rsp_id  <= 1'b1;
            last    <= 1'b1;
            sc      <= SC_INIT;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (sc != '0) begin
            sc <= sc - 1'b1;
          end else begin
            rsp_y     <= alu_y;
            rsp_flags <= {alu_n, alu_z, alu_c, alu_v};
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            if (rsp_id) cnt1 <= cnt1 + 1'b1;
            else        cnt0 <= cnt0 + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
